// File: rtl/target_locator.sv
// rtl/target_locator.sv - red-dominance target locator; bounding-box centre per frame
// Optional build macro TARGET_LOCATOR_CLAMP_EN keeps a 128x128 box around the centre on-screen.
module target_locator #(
    parameter int          H_ACTIVE  = 800,
    parameter int          V_ACTIVE  = 600,
    parameter logic [9:0]  R_MIN     = 10'd512,
    parameter logic [9:0]  MARGIN    = 10'd128,
    parameter logic [18:0] MIN_COUNT = 19'd64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic [31:0] i_data,
    output logic        o_start,
    output logic        o_done,
    output logic        o_found,
    output logic [9:0]  o_row,
    output logic [9:0]  o_col,
    output logic        o_busy
);
    localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_SCAN, S_CALC} state_t;
    state_t state, state_nxt;

    logic [9:0]  row_cnt, col_cnt;
    logic [9:0]  min_row, min_col, max_row, max_col;
    logic [18:0] count;
    logic        take, restart, calc_en, last_px, is_target, found;
    logic [9:0]  cur_row, cur_col, ctr_row, ctr_col;
    logic [9:0]  base_min_row, base_min_col, base_max_row, base_max_col;
    logic [18:0] base_count;
    logic [10:0] sum_row, sum_col;
    logic [9:0]  pix_r, pix_g, pix_b;
    logic        unused_pad;

    assign pix_r      = i_data[29:20];
    assign pix_g      = i_data[19:10];
    assign pix_b      = i_data[9:0];
    assign unused_pad = ^i_data[31:30];

    assign is_target = (pix_r >= R_MIN)
                    && ({1'b0, pix_r} > ({1'b0, pix_g} + {1'b0, MARGIN}))
                    && ({1'b0, pix_r} > ({1'b0, pix_b} + {1'b0, MARGIN}));

    // An sof pixel always restarts the frame at (0,0), whether arming or mid-scan.
    assign cur_row = restart ? 10'd0 : row_cnt;
    assign cur_col = restart ? 10'd0 : col_cnt;
    assign last_px = take && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    assign base_min_row = restart ? 10'h3ff : min_row;
    assign base_min_col = restart ? 10'h3ff : min_col;
    assign base_max_row = restart ? 10'h000 : max_row;
    assign base_max_col = restart ? 10'h000 : max_col;
    assign base_count   = restart ? 19'd0   : count;

    assign sum_row = {1'b0, min_row} + {1'b0, max_row};
    assign sum_col = {1'b0, min_col} + {1'b0, max_col};
    assign found   = (count >= MIN_COUNT);

`ifdef TARGET_LOCATOR_CLAMP_EN
    localparam logic [9:0] ROW_HI = 10'(V_ACTIVE - 65);
    localparam logic [9:0] COL_HI = 10'(H_ACTIVE - 65);
    always_comb begin
        ctr_row = sum_row[10:1];
        ctr_col = sum_col[10:1];
        if (ctr_row < 10'd64)     ctr_row = 10'd64;
        else if (ctr_row > ROW_HI) ctr_row = ROW_HI;
        if (ctr_col < 10'd64)     ctr_col = 10'd64;
        else if (ctr_col > COL_HI) ctr_col = COL_HI;
    end
`else
    assign ctr_row = sum_row[10:1];
    assign ctr_col = sum_col[10:1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_ARM;
            S_ARM:   if (take)    state_nxt = last_px ? S_CALC : S_SCAN;
            S_SCAN:  if (last_px) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        take    = 1'b0;
        restart = 1'b0;
        calc_en = 1'b0;
        o_busy  = 1'b0;
        case (state)
            S_ARM: begin
                o_busy  = 1'b1;
                take    = i_valid & i_sof;
                restart = i_valid & i_sof;
            end
            S_SCAN: begin
                o_busy  = 1'b1;
                take    = i_valid;
                restart = i_valid & i_sof;
            end
            S_CALC: begin
                o_busy  = 1'b1;
                calc_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
            min_row <= '0;
            min_col <= '0;
            max_row <= '0;
            max_col <= '0;
            count   <= '0;
            o_start <= 1'b0;
            o_done  <= 1'b0;
            o_found <= 1'b0;
            o_row   <= '0;
            o_col   <= '0;
        end else begin
            o_start <= 1'b0;
            o_done  <= 1'b0;
            if (take) begin
                if (cur_col == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (cur_row == ROW_LAST) ? 10'd0 : cur_row + 10'd1;
                end else begin
                    col_cnt <= cur_col + 10'd1;
                    row_cnt <= cur_row;
                end
                min_row <= (is_target && cur_row < base_min_row) ? cur_row : base_min_row;
                min_col <= (is_target && cur_col < base_min_col) ? cur_col : base_min_col;
                max_row <= (is_target && cur_row > base_max_row) ? cur_row : base_max_row;
                max_col <= (is_target && cur_col > base_max_col) ? cur_col : base_max_col;
                count   <= (is_target && base_count != 19'h7ffff) ? base_count + 19'd1 : base_count;
            end
            if (calc_en) begin
                o_done  <= 1'b1;
                o_found <= found;
                if (found) begin
                    o_start <= 1'b1;
                    o_row   <= ctr_row;
                    o_col   <= ctr_col;
                end
            end
        end
    end
endmodule

// File: doc/target_locator.md
# target_locator

Frame-level object locator that sits directly upstream of the box-overlay image generator. It scans one 800x600 raster frame of `{2'b0,R,G,B}` pixels and classifies each pixel as target or background with a red-dominance threshold. It tracks the bounding box of the target pixels and, at end of frame, issues the box centre as a start pulse plus row/col for the overlay stage.

## Interface
- `H_ACTIVE`, 800: pixels per line.
- `V_ACTIVE`, 600: lines per frame.
- `R_MIN`, 10'd512: minimum R for a target pixel.
- `MARGIN`, 10'd128: R must exceed both G and B by more than this.
- `MIN_COUNT`, 19'd64: minimum target-pixel count for a valid detection.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  arm for next frame; if held high, the block re-arms every frame.
- `i_valid`  in  1  pixel qualifier.
- `i_sof`  in  1  start of frame; meaningful only with `i_valid`; marks pixel (0,0).
- `i_data`  in  32  `{2'b0, R[29:20], G[19:10], B[9:0]}`.
- `o_start`  out  1  one-cycle pulse: detection complete and found.
- `o_done`  out  1  one-cycle pulse: frame scan finished, found or not.
- `o_found`  out  1  level; result of the last completed frame.
- `o_row`  out  10  centre row; holds its value between frames.
- `o_col`  out  10  centre column; holds its value between frames.
- `o_busy`  out  1  high in S_ARM, S_SCAN and S_CALC.

## Operation
- States:
  - S_IDLE: `i_start` -> S_ARM.
  - S_ARM: waits for `i_valid & i_sof`. That pixel is processed as (0,0), and the block goes to S_SCAN with col=1, row=0.
  - S_SCAN: each `i_valid` pixel is processed and the col/row counters advance. Col wraps at H_ACTIVE-1 and increments row. Processing pixel (V_ACTIVE-1, H_ACTIVE-1) -> S_CALC.
  - S_CALC: one cycle, result computed -> S_IDLE.
- Target test: R >= R_MIN && R > G+MARGIN && R > B+MARGIN. Sums are 11-bit, with no overflow wrap.
- On entry to the frame (the sof pixel):
  - min_row/min_col are set to 1023.
  - max_row/max_col are set to 0.
  - count is set to 0.
  - These are then updated by the sof pixel itself.
- Each target pixel:
  - min/max are updated with the current row/col.
  - count is incremented, saturating at 2^19-1.
- Centre: row = (min_row+max_row)>>1 and col = (min_col+max_col)>>1, using 11-bit sums and truncating.
- found = count >= MIN_COUNT.
  - If found: `o_row`/`o_col`/`o_found` are updated, and `o_start` and `o_done` pulse.
  - Else: `o_found`=0, `o_row`/`o_col` keep their previous values, only `o_done` pulses.
- `i_sof` with `i_valid` while in S_SCAN (short frame): the partial frame is discarded. Accumulators are re-initialised, and that pixel is treated as (0,0). No `o_done` is issued for the partial frame.
- `i_valid` low: counters and accumulators hold. Pixels outside S_ARM/S_SCAN are ignored.
- `i_start` is ignored outside S_IDLE. The S_CALC -> S_IDLE transition with `i_start` high re-arms one cycle later.

## Timing
- Reset values: state S_IDLE, `o_start`=0, `o_done`=0, `o_found`=0, `o_row`=0, `o_col`=0, `o_busy`=0. All accumulators and counters are 0.
- Reset mid-frame: immediate return to S_IDLE. Previous results are lost.
- Last pixel accepted at cycle N: S_CALC at N+1. `o_start`/`o_done`/`o_row`/`o_col`/`o_found` are registered and visible at N+2.
- `o_row`/`o_col` are valid in the same cycle as `o_start` and stable until the next `o_start`. The downstream stage samples them on `o_start`.
- Throughput: one pixel per clock. No backpressure.

## Configuration
- `TARGET_LOCATOR_CLAMP_EN` defined:
  - The centre is clamped so a 128x128 box stays on-screen.
  - Row is clamped to [64, V_ACTIVE-65], i.e. [64,535].
  - Col is clamped to [64, H_ACTIVE-65], i.e. [64,735].
  - The clamp adds no latency and is applied in S_CALC.
- Undefined: the raw bounding-box centre is output. It may lie within 64 of an edge.

## Test plan
- Black frame (all 0), `i_start` pulsed: `o_done` pulses once, `o_start` stays 0, `o_found`=0, `o_row`/`o_col` stay 0.
- Red square R=1023, G=B=0 at rows 100..199, cols 300..399 on a black frame:
  - `o_start` pulses at last-pixel+2.
  - `o_row`=149, `o_col`=349, `o_found`=1.
- Red 8x8 block at rows 0..7, cols 0..7 (count 64): `o_found`=1, with two cases.
  - Clamp undefined: `o_row`=3, `o_col`=3.
  - `TARGET_LOCATOR_CLAMP_EN`: `o_row`=64, `o_col`=64.
- Threshold edges:
  - R=640,G=512 is rejected (R-G=128, not > MARGIN).
  - R=641,G=512,B=0 is accepted.
  - R=511,G=B=0 is rejected.
  - A 100x100 block of each gives found=0/1/0 respectively.
- Second `i_sof` asserted at row 300:
  - The partial frame is discarded with no `o_done`.
  - The following full frame with a square at rows 400..499, cols 0..99 yields `o_row`=449, `o_col`=49.
- Reset and re-arm:
  - `i_rst_n` asserted at row 250 of a scanning frame: all outputs are 0 asynchronously.
  - After release, a new `i_start` and full frame produce a correct result.
  - `i_start` held high over 3 frames gives 3 `o_done` pulses.
